// File: rtl/guia06_sweep_ctrl.sv
// guia06_sweep_ctrl: steps the Guia06 function (s = x&~z | x&~y) through all 8 input
// vectors, captures its truth table and compares it against EXPECT.
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start, abort      begin a sweep (IDLE only) / cancel a running sweep
//   s_in              output s of the function under test
//   x, y, z           function inputs, {x,y,z} = current vector index
//   busy, done        sweep in progress / one-cycle completion pulse
//   pass              captured table == EXPECT, valid from done until next start
//   table_out         captured table, bit[idx] = s for idx = {x,y,z}
//   fail_idx          lowest mismatching index (0 when pass)
//   fail_cnt          number of mismatching entries
module guia06_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXPECT = 8'h70
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       s_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out,
  output logic [2:0] fail_idx,
  output logic [3:0] fail_cnt
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t     state_q;
  logic [2:0] idx_q;
  logic [3:0] cnt_q;
  logic [2:0] xyz_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] table_q;
  logic [2:0] fidx_q;
  logic [3:0] fcnt_q;
  logic [7:0] diff;
  logic [2:0] fidx_d;
  logic [3:0] fcnt_d;
  // Descending scan so the last hit left in fidx_d is the lowest mismatching index.
  always_comb begin
    diff   = table_q ^ EXPECT;
    fidx_d = '0;
    fcnt_d = '0;
    for (int i = 7; i >= 0; i--) begin
      if (diff[i]) fidx_d = 3'(i);
      fcnt_d = fcnt_d + {3'b000, diff[i]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      xyz_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= '0;
      fidx_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // Abort takes effect before any capture in the same cycle; the partial table stays.
      if (abort && (state_q == DRIVE || state_q == SAMPLE)) begin
        state_q <= IDLE;
        xyz_q   <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
        fcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: if (start && !abort) begin
            state_q <= DRIVE;
            idx_q   <= '0;
            cnt_q   <= 4'(SETTLE);
            xyz_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            table_q <= '0;
            fidx_q  <= '0;
            fcnt_q  <= '0;
          end
          DRIVE: if (cnt_q == '0) state_q <= SAMPLE;
                 else cnt_q <= cnt_q - 4'd1;
          SAMPLE: begin
            table_q[idx_q] <= s_in;
            if (idx_q == 3'd7) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 3'd1;
              xyz_q   <= idx_q + 3'd1;
              cnt_q   <= 4'(SETTLE);
              state_q <= DRIVE;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            pass_q  <= (diff == '0);
            fidx_q  <= fidx_d;
            fcnt_q  <= fcnt_d;
            xyz_q   <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign {x, y, z}  = xyz_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign table_out  = table_q;
  assign fail_idx   = fidx_q;
  assign fail_cnt   = fcnt_q;
endmodule

// File: tb/tb_guia06_sweep_ctrl.sv
// tb_guia06_sweep_ctrl: table-driven sweeps against modelled good/faulty Guia06 functions.
module tb_guia06_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_in;
  logic       x, y, z, busy, done, pass;
  logic [7:0] table_out;
  logic [2:0] fail_idx;
  logic [3:0] fail_cnt;
  int         mode = 0;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    int         mode;
    logic [7:0] tbl;
    logic       p;
    logic [2:0] fi;
    logic [3:0] fc;
  } vec_t;
  vec_t vecs[4];
  always #5 clk = ~clk;
  // mode 0 golden, 1 stuck-1, 2 stuck-0 at idx 6 only, 3 stuck-0
  assign s_in = (mode == 1) ? 1'b1 :
                (mode == 3) ? 1'b0 :
                ((x & ~z) | (x & ~y)) & ~(mode == 2 && {x, y, z} == 3'd6);
  guia06_sweep_ctrl #(.SETTLE(1), .EXPECT(8'h70)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s_in(s_in),
    .x(x), .y(y), .z(z), .busy(busy), .done(done), .pass(pass),
    .table_out(table_out), .fail_idx(fail_idx), .fail_cnt(fail_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Pulses start, then watches 40 cycles; cycle n is the state after the n-th edge past start.
  task automatic sweep(input int restart_at, output int done_at, output int ndone);
    int xyz_bad;
    xyz_bad = 0;
    done_at = -1;
    ndone   = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    if ({x, y, z} != 3'd0) xyz_bad++;
    for (int n = 1; n <= 40; n++) begin
      step();
      start = (n == restart_at);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
      if (n <= 23 && {x, y, z} != 3'(n / 3)) xyz_bad++;
      if (n == 12) chk("busy_mid", 32'(busy), 32'd1);
      if (n == 25) chk("busy_at_done", 32'(busy), 32'd0);
    end
    start = 1'b0;
    chk("xyz_steps", xyz_bad, 0);
    chk("xyz_idle", 32'({x, y, z}), 32'd0);
  endtask
  initial begin
    int done_at, ndone;
    vecs[0] = '{mode: 0, tbl: 8'h70, p: 1'b1, fi: 3'd0, fc: 4'd0};
    vecs[1] = '{mode: 1, tbl: 8'hFF, p: 1'b0, fi: 3'd0, fc: 4'd5};
    vecs[2] = '{mode: 2, tbl: 8'h30, p: 1'b0, fi: 3'd6, fc: 4'd1};
    vecs[3] = '{mode: 3, tbl: 8'h00, p: 1'b0, fi: 3'd4, fc: 4'd3};
    #12;
    chk("rst_outs", 32'({x, y, z, busy, done, pass, table_out, fail_idx, fail_cnt}), 32'd0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      sweep(-1, done_at, ndone);
      chk("done_cycle", done_at, 25);
      chk("done_count", ndone, 1);
      chk("table_out", 32'(table_out), 32'(vecs[i].tbl));
      chk("pass", 32'(pass), 32'(vecs[i].p));
      chk("fail_idx", 32'(fail_idx), 32'(vecs[i].fi));
      chk("fail_cnt", 32'(fail_cnt), 32'(vecs[i].fc));
    end
    mode = 0;
    sweep(5, done_at, ndone);
    chk("restart_done_cycle", done_at, 25);
    chk("restart_done_count", ndone, 1);
    chk("restart_table", 32'(table_out), 32'h70);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    step();
    chk("start_abort_idle", 32'(busy), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 11; n++) step();
    chk("abort_pre_xyz", 32'({x, y, z}), 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_xyz", 32'({x, y, z}), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("abort_table", 32'(table_out), 32'h00);
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    sweep(-1, done_at, ndone);
    chk("post_abort_done", done_at, 25);
    chk("post_abort_table", 32'(table_out), 32'h70);
    chk("post_abort_pass", 32'(pass), 32'd1);
    mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 4; n++) step();
    chk("pre_rst_table", 32'(table_out), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'({x, y, z, busy, done, pass, table_out, fail_idx, fail_cnt}), 32'd0);
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (done || busy || {x, y, z} != 3'd0) ndone++;
    end
    chk("rst_stays_idle", ndone, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
